// File: rtl/ifu_prefetch_pkg.sv
// Shared fetch-path constants and the buffer entry type.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Contents:
//   XLEN, INSTR_W    address and instruction widths
//   RESET_PC_DEF     default first fetch address after reset
//   fetch_ent_t      one buffered {pc, instr} pair
//   word_align()     clears the byte-offset bits of an address
package ifu_prefetch_pkg;

   localparam int XLEN    = 32;
   localparam int INSTR_W = 32;

   localparam logic [XLEN-1:0] RESET_PC_DEF = 32'h8000_0000;

   // pc sits in the upper half so a whole entry reads naturally as {pc, instr}.
   typedef struct packed {
      logic [XLEN-1:0]    pc;
      logic [INSTR_W-1:0] instr;
   } fetch_ent_t;

   // Instruction fetches are word granular; byte-offset bits are dropped.
   function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
      return addr & ~XLEN'(3);
   endfunction

endpackage

// File: rtl/ifu_fifo.sv
// Synchronous FIFO of DEPTH {pc, instr} entries with push/pop/flush.
// Latency: a push becomes visible at head_dat one cycle later; there is no bypass path.
// Backpressure: none here; the caller guarantees a push is only issued when there is room (or a pop happens in the same cycle).
//
// Ports:
//   clk, rst            clock; synchronous active-low reset
//   push, push_dat      write one entry at the tail
//   pop                 drop the head entry
//   flush               empty the FIFO (wins over push and pop)
//   head_dat            current head entry (registered storage)
//   full, empty, count  occupancy status
module ifu_fifo
   import ifu_prefetch_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   push,
   input  fetch_ent_t             push_dat,
   input  logic                   pop,
   input  logic                   flush,
   output fetch_ent_t             head_dat,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   // The pointers carry one extra MSB. Equal pointers mean empty.
   // Pointers that differ only in that MSB mean full.
   logic [CW-1:0] wr_ptr_q, wr_ptr_d;
   logic [CW-1:0] rd_ptr_q, rd_ptr_d;
   fetch_ent_t    mem_q [DEPTH];
   fetch_ent_t    mem_d [DEPTH];

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      mem_d    = mem_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
      end else begin
         // When full with a pop in the same cycle, the write lands in the slot
         // being vacated. The popped value was already read from mem_q this cycle.
         if (push) begin
            mem_d[wr_ptr_q[AW-1:0]] = push_dat;
            wr_ptr_d                = wr_ptr_q + CW'(1);
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + CW'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         mem_q    <= '{default: '0};
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         mem_q    <= mem_d;
      end
   end

   assign head_dat = mem_q[rd_ptr_q[AW-1:0]];
   assign empty    = (wr_ptr_q == rd_ptr_q);
   assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign count    = wr_ptr_q - rd_ptr_q;

   a_no_overflow : assert property (@(posedge clk) disable iff (!rst)
      (push && !flush) |-> (!full || pop));
   a_no_underflow : assert property (@(posedge clk) disable iff (!rst)
      (pop && !flush) |-> !empty);

endmodule

// File: rtl/ifu_prefetch.sv
// Instruction prefetch: sequential word fetches over req/gnt + rvalid, buffered and handed to the core.
// Latency: rvalid in cycle k gives if_valid in cycle k+1 at the earliest; a redirect in cycle r allows a new request in r+1.
// Backpressure: if_ready stalls the buffer. Requests are credit-limited (inflight + count < DEPTH), so rvalid is never backpressured.
//
// Ports:
//   clk, rst                      clock; synchronous active-low reset
//   redirect_valid, redirect_pc   fetch restart from the core (highest priority)
//   imem_req/addr/gnt             fetch request channel
//   imem_rvalid/rdata             in-order response channel
//   if_valid/instr/pc, if_ready   {pc, instr} delivery to the core
module ifu_prefetch
   import ifu_prefetch_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEF,
   parameter int              DEPTH    = 2
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               redirect_valid,
   input  logic [XLEN-1:0]    redirect_pc,
   output logic               imem_req,
   output logic [XLEN-1:0]    imem_addr,
   input  logic               imem_gnt,
   input  logic               imem_rvalid,
   input  logic [INSTR_W-1:0] imem_rdata,
   output logic               if_valid,
   output logic [INSTR_W-1:0] if_instr,
   output logic [XLEN-1:0]    if_pc,
   input  logic               if_ready
);

   localparam int CW = $clog2(DEPTH) + 1;
   localparam logic [CW:0] DEPTH_C = (CW+1)'(DEPTH);

   // fetch_pc: next address to request.
   // resp_pc:  address of the next response that will be kept.
   logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
   logic [XLEN-1:0] resp_pc_q,  resp_pc_d;

   // inflight: granted requests whose response has not yet arrived.
   // discard:  how many of those belong to a fetch stream a redirect abandoned.
   logic [CW-1:0]   inflight_q, inflight_d;
   logic [CW-1:0]   discard_q,  discard_d;

   logic            fifo_push;
   logic            fifo_pop;
   logic            fifo_full;
   logic            fifo_empty;
   logic [CW-1:0]   fifo_count;
   fetch_ent_t      fifo_head;
   fetch_ent_t      fifo_wdat;

   logic [CW:0]     credit_used;
   logic            gnt_fire;
   logic            rsp_fire;
   logic            rsp_keep;

   // Every buffer slot is reserved when its request is issued. Responses
   // therefore always have somewhere to land, with no rvalid backpressure.
   assign credit_used = {1'b0, inflight_q} + {1'b0, fifo_count};

   assign imem_req  = rst && !redirect_valid && (credit_used < DEPTH_C);
   assign imem_addr = fetch_pc_q;
   assign gnt_fire  = imem_req && imem_gnt;

   assign rsp_fire  = rst && imem_rvalid;
   // Drop a response if it belongs to an abandoned stream or arrives during a redirect.
   assign rsp_keep  = rsp_fire && !redirect_valid && (discard_q == '0);

   assign if_valid  = rst && !fifo_empty && !redirect_valid;
   assign if_pc     = rst ? fifo_head.pc    : '0;
   assign if_instr  = rst ? fifo_head.instr : '0;

   assign fifo_pop  = if_valid && if_ready;
   assign fifo_push = rsp_keep;
   assign fifo_wdat = '{pc: resp_pc_q, instr: imem_rdata};

   always_comb begin
      fetch_pc_d = fetch_pc_q;
      resp_pc_d  = resp_pc_q;
      discard_d  = discard_q;
      // No grant can coincide with a redirect, so this sum is also correct in redirect cycles.
      inflight_d = inflight_q + CW'(gnt_fire) - CW'(rsp_fire);

      if (redirect_valid) begin
         fetch_pc_d = word_align(redirect_pc);
         resp_pc_d  = word_align(redirect_pc);
         // Every request still outstanding after this cycle belongs to the old
         // stream, including responses an earlier redirect was already discarding.
         discard_d  = inflight_q - CW'(rsp_fire);
      end else begin
         if (gnt_fire) begin
            fetch_pc_d = fetch_pc_q + XLEN'(4);
         end
         if (rsp_fire) begin
            if (discard_q != '0) begin
               discard_d = discard_q - CW'(1);
            end else begin
               resp_pc_d = resp_pc_q + XLEN'(4);
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         fetch_pc_q <= RESET_PC;
         resp_pc_q  <= RESET_PC;
         inflight_q <= '0;
         discard_q  <= '0;
      end else begin
         fetch_pc_q <= fetch_pc_d;
         resp_pc_q  <= resp_pc_d;
         inflight_q <= inflight_d;
         discard_q  <= discard_d;
      end
   end

   ifu_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk      (clk),
      .rst      (rst),
      .push     (fifo_push),
      .push_dat (fifo_wdat),
      .pop      (fifo_pop),
      .flush    (redirect_valid),
      .head_dat (fifo_head),
      .full     (fifo_full),
      .empty    (fifo_empty),
      .count    (fifo_count)
   );

   a_credit_bound : assert property (@(posedge clk) disable iff (!rst)
      credit_used <= DEPTH_C);
   a_inflight_bound : assert property (@(posedge clk) disable iff (!rst)
      {1'b0, inflight_q} <= DEPTH_C);
   a_discard_bound : assert property (@(posedge clk) disable iff (!rst)
      discard_q <= inflight_q);
   a_rsp_expected : assert property (@(posedge clk) disable iff (!rst)
      imem_rvalid |-> (inflight_q != '0));
   a_push_has_room : assert property (@(posedge clk) disable iff (!rst)
      fifo_push |-> (!fifo_full || fifo_pop));

endmodule

// File: tb/tb_ifu_prefetch.sv
// Randomized scoreboard bench for ifu_prefetch with an in-order memory model.
// Latency: memory responses take 1..lat_max cycles after grant.
// Backpressure: gnt and if_ready are randomized, with directed phases.
module tb_ifu_prefetch;

   localparam int          DEPTH    = 2;
   localparam logic [31:0] RESET_PC = 32'h8000_0000;
   localparam int          NCYC     = 2000;

   logic        clk = 1'b0;
   logic        rst;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic        if_valid;
   logic [31:0] if_instr;
   logic [31:0] if_pc;
   logic        if_ready;

   always #5 clk = ~clk;

   ifu_prefetch #(
      .RESET_PC (RESET_PC),
      .DEPTH    (DEPTH)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .imem_req       (imem_req),
      .imem_addr      (imem_addr),
      .imem_gnt       (imem_gnt),
      .imem_rvalid    (imem_rvalid),
      .imem_rdata     (imem_rdata),
      .if_valid       (if_valid),
      .if_instr       (if_instr),
      .if_pc          (if_pc),
      .if_ready       (if_ready)
   );

   // A granted request: its address, the fetch stream it belongs to, and the cycle its response is due.
   typedef struct {
      logic [31:0] addr;
      int          epoch;
      int          due;
   } pend_t;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] instr;
   } exp_t;

   pend_t mem_pend[$];   // outstanding memory requests, in order
   exp_t  sb_q[$];       // entries the core should see, in order

   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   int          epoch = 0;
   int          lat_max = 1;
   int          last_due = 0;
   int          delivered = 0;
   logic [31:0] exp_fetch_pc = RESET_PC;
   bit          drv_rsp = 1'b0;
   bit          drv_push = 1'b0;
   exp_t        drv_ent;
   bit          done = 1'b0;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s cyc=%0d: got %h expected %h", name, cyc, act, exp);
      end
   endtask

   // Driver: chooses this cycle's inputs at the falling edge.
   initial begin
      rst            = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = '0;
      imem_gnt       = 1'b0;
      imem_rvalid    = 1'b0;
      imem_rdata     = '0;
      if_ready       = 1'b0;
      for (int c = 0; c < NCYC; c++) begin
         @(negedge clk);
         cyc            = c;
         rst            = 1'b1;
         redirect_valid = 1'b0;
         redirect_pc    = $urandom;
         if (c < 4) begin
            rst = 1'b0; imem_gnt = 1'b1; if_ready = 1'b1; lat_max = 1;
         end else if (c < 44) begin
            imem_gnt = 1'b1; if_ready = 1'b1; lat_max = 1;
         end else if (c < 64) begin
            imem_gnt = 1'b1; if_ready = (c >= 54); lat_max = 1;
         end else if (c < 80) begin
            imem_gnt = (c >= 67); if_ready = 1'b1; lat_max = (c >= 72) ? 3 : 1;
         end else if (c < 120) begin
            imem_gnt = ($urandom_range(0, 99) < 80);
            if_ready = 1'b1;
            lat_max  = 3;
            if (c == 80) begin
               redirect_valid = 1'b1; redirect_pc = 32'h8000_0103;
            end
            if (c == 100) redirect_valid = 1'b1;
            if (c == 110) begin
               redirect_valid = 1'b1; redirect_pc = 32'h8000_1000;
            end
            if (c == 111) begin
               redirect_valid = 1'b1; redirect_pc = 32'h8000_2006;
            end
            if (c == 115) begin
               redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFF9;
            end
         end else if (c < 140) begin
            imem_gnt = 1'b1; if_ready = 1'b0; lat_max = 2;
         end else if (c < 142) begin
            rst = 1'b0; if_ready = 1'b0;
         end else begin
            imem_gnt       = ($urandom_range(0, 99) < 70);
            if_ready       = ($urandom_range(0, 99) < 70);
            lat_max        = 4;
            redirect_valid = ($urandom_range(0, 99) < 3);
            if ($urandom_range(0, 299) == 0) begin
               rst = 1'b0; redirect_valid = 1'b0;
            end
         end

         // Memory responder: in order, one response per cycle at most.
         drv_rsp  = 1'b0;
         drv_push = 1'b0;
         if (rst && mem_pend.size() > 0 && mem_pend[0].due <= c) begin
            pend_t p;
            p           = mem_pend.pop_front();
            imem_rvalid = 1'b1;
            imem_rdata  = mem_word(p.addr);
            drv_rsp     = 1'b1;
            if (!redirect_valid && p.epoch == epoch) begin
               drv_push = 1'b1;
               drv_ent  = '{pc: p.addr, instr: mem_word(p.addr)};
            end
         end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = $urandom;
         end

         if (c == 44) check("throughput_phase1", 32'(delivered >= 20), 32'd1);
      end
      @(negedge clk);
      done = 1'b1;
      check("liveness_total", 32'(delivered > 100), 32'd1);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   // Monitor: compares the DUT against the model, then advances the model across the next rising edge.
   initial begin
      forever begin
         int  outstanding;
         bit  exp_req;
         bit  exp_vld;
         @(negedge clk);
         #2;
         if (done) break;

         outstanding = mem_pend.size() + (drv_rsp ? 1 : 0);
         exp_req = rst && !redirect_valid && (outstanding + sb_q.size() < DEPTH);
         exp_vld = rst && !redirect_valid && (sb_q.size() > 0);

         check("imem_req", 32'(imem_req), 32'(exp_req));
         if (exp_req && imem_req) check("imem_addr", imem_addr, exp_fetch_pc);
         check("if_valid", 32'(if_valid), 32'(exp_vld));
         if (exp_vld && if_valid) begin
            check("if_pc", if_pc, sb_q[0].pc);
            check("if_instr", if_instr, sb_q[0].instr);
         end
         if (!rst) begin
            check("reset_if_pc", if_pc, 32'd0);
            check("reset_if_instr", if_instr, 32'd0);
         end

         if (!rst) begin
            mem_pend.delete();
            sb_q.delete();
            exp_fetch_pc = RESET_PC;
            last_due     = 0;
         end else if (redirect_valid) begin
            sb_q.delete();
            epoch++;
            exp_fetch_pc = redirect_pc & 32'hFFFF_FFFC;
         end else begin
            if (exp_vld && if_ready) begin
               void'(sb_q.pop_front());
               delivered++;
            end
            if (exp_req && imem_gnt) begin
               int due;
               due = cyc + int'($urandom_range(1, lat_max));
               if (due <= last_due) due = last_due + 1;
               last_due = due;
               mem_pend.push_back('{addr: exp_fetch_pc, epoch: epoch, due: due});
               exp_fetch_pc = exp_fetch_pc + 32'd4;
            end
            if (drv_push) sb_q.push_back(drv_ent);
         end
      end
   end

endmodule
